// File: rtl/regfile_pkg.sv
// Shared definitions for the reg_file_sb register file.
// Holds default address/data widths, the register-count derivation and the
// address/data typedefs used by the pipeline around the register file.
package regfile_pkg;

  localparam int REGFILE_ADDR_W = 5;
  localparam int REGFILE_DATA_W = 32;

  typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;
  typedef logic [REGFILE_DATA_W-1:0] reg_data_t;

  // Number of architectural registers addressable with addr_w bits.
  function automatic int num_regs(input int addr_w);
    return 32'sd1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_file_sb_decoder_onehot.sv
// Generic one-hot decoder: onehot = 1 << sel while en is high, else all zero.
// Used for both the write-port decode and the reservation decode.
module decoder_onehot #(
  parameter int N_IN = 5
) (
  input  logic [N_IN-1:0]          sel,
  input  logic                     en,
  output logic [(1 << N_IN)-1:0]   onehot
);

  // Drive exactly one output line for the selected index when enabled.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with a per-register busy scoreboard.
// One write port (writeback), two combinational read ports (decode) and a
// reservation port (issue) that marks a destination busy until it is written.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN -- when defined, a write
// in flight to the address being read is forwarded to the read port in the
// same cycle (write-through), so writeback and decode can overlap.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  input  logic [ADDR_W-1:0]          raddr_a,
  output logic [DATA_W-1:0]          rdata_a,
  output logic                       rbusy_a,
  input  logic [ADDR_W-1:0]          raddr_b,
  output logic [DATA_W-1:0]          rdata_b,
  output logic                       rbusy_b,
  output logic [(1 << ADDR_W)-1:0]   busy_vec
);

  localparam int NUM_REGS = num_regs(ADDR_W);

  // Registers that can actually hold state; register 0 drops out when it is
  // hardwired to zero, which also keeps it permanently non-busy.
  localparam logic [NUM_REGS-1:0] LIVE_MASK =
    (ZERO_REG != 0) ? {{(NUM_REGS-1){1'b1}}, 1'b0} : {NUM_REGS{1'b1}};

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] wr_sel;
  logic [NUM_REGS-1:0] rsv_sel;

  // True when addr names a register that stores data (not the zero register).
  function automatic logic is_live(input logic [ADDR_W-1:0] addr);
    return !((ZERO_REG != 0) && (addr == {ADDR_W{1'b0}}));
  endfunction

  decoder_onehot #(.N_IN(ADDR_W)) u_wr_dec (
    .sel    (waddr),
    .en     (we),
    .onehot (wr_sel)
  );

  decoder_onehot #(.N_IN(ADDR_W)) u_rsv_dec (
    .sel    (rsv_addr),
    .en     (rsv_en),
    .onehot (rsv_sel)
  );

  // Data array: clear on reset, otherwise store wdata into the decoded register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i] && LIVE_MASK[i]) begin
          regs[i] <= wdata;
        end
      end
    end
  end

  // Scoreboard: writeback releases, issue reserves; a reservation landing on
  // the same register as a retiring write wins because it names a newer producer.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~wr_sel) | rsv_sel) & LIVE_MASK;
    end
  end

  assign busy_vec = busy;

  // Read port A: registered value, zero register forced, optional write-through.
  always_comb begin
    rdata_a = '0;
    rbusy_a = 1'b0;
    if (is_live(raddr_a)) begin
`ifdef REGFILE_WRITE_BYPASS_EN
      if (we && (waddr == raddr_a)) begin
        rdata_a = wdata;
        rbusy_a = rsv_en && (rsv_addr == waddr);
      end else begin
        rdata_a = regs[raddr_a];
        rbusy_a = busy[raddr_a];
      end
`else
      rdata_a = regs[raddr_a];
      rbusy_a = busy[raddr_a];
`endif
    end else begin
      rdata_a = '0;
      rbusy_a = 1'b0;
    end
  end

  // Read port B: same rules as port A, independent address.
  always_comb begin
    rdata_b = '0;
    rbusy_b = 1'b0;
    if (is_live(raddr_b)) begin
`ifdef REGFILE_WRITE_BYPASS_EN
      if (we && (waddr == raddr_b)) begin
        rdata_b = wdata;
        rbusy_b = rsv_en && (rsv_addr == waddr);
      end else begin
        rdata_b = regs[raddr_b];
        rbusy_b = busy[raddr_b];
      end
`else
      rdata_b = regs[raddr_b];
      rbusy_b = busy[raddr_b];
`endif
    end else begin
      rdata_b = '0;
      rbusy_b = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: default 32x32 instance with a zero
// register, plus an 8x16 instance without one. Both are compared every cycle
// against a simple array/scoreboard model, and directed steps pin known values.
module tb_reg_file_sb;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        we, rsv_en;
  logic [4:0]  waddr, rsv_addr, raddr_a, raddr_b;
  logic [31:0] wdata;
  logic [31:0] rdata_a, rdata_b;
  logic        rbusy_a, rbusy_b;
  logic [31:0] busy_vec;

  logic        p_we, p_rsv_en;
  logic [2:0]  p_waddr, p_rsv_addr, p_raddr_a, p_raddr_b;
  logic [15:0] p_wdata;
  logic [15:0] p_rdata_a, p_rdata_b;
  logic        p_rbusy_a, p_rbusy_b;
  logic [7:0]  p_busy_vec;

  int n_err = 0;
  int n_chk = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  reg_file_sb u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .rbusy_a(rbusy_a),
    .raddr_b(raddr_b), .rdata_b(rdata_b), .rbusy_b(rbusy_b),
    .busy_vec(busy_vec)
  );

  reg_file_sb #(.ADDR_W(3), .DATA_W(16), .ZERO_REG(0)) u_dut_p (
    .clk(clk), .rst(rst), .we(p_we), .waddr(p_waddr), .wdata(p_wdata),
    .rsv_en(p_rsv_en), .rsv_addr(p_rsv_addr),
    .raddr_a(p_raddr_a), .rdata_a(p_rdata_a), .rbusy_a(p_rbusy_a),
    .raddr_b(p_raddr_b), .rdata_b(p_rdata_b), .rbusy_b(p_rbusy_b),
    .busy_vec(p_busy_vec)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  logic [15:0] q_regs [8];
  bit          q_busy [8];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = 32'h0; m_busy[i] = 1'b0; end
      for (int i = 0; i < 8; i++)  begin q_regs[i] = 16'h0; q_busy[i] = 1'b0; end
    end else begin
      if (we && waddr != 5'd0) begin m_regs[waddr] = wdata; m_busy[waddr] = 1'b0; end
      if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
      if (p_we) begin q_regs[p_waddr] = p_wdata; q_busy[p_waddr] = 1'b0; end
      if (p_rsv_en) q_busy[p_rsv_addr] = 1'b1;
    end
  end

  function automatic logic [32:0] exp_main(input logic [4:0] ra);
    logic [31:0] d;
    logic        b;
    d = m_regs[ra];
    b = m_busy[ra];
    if (BYP && we && waddr == ra) begin
      d = wdata;
      b = rsv_en && (rsv_addr == waddr);
    end
    if (ra == 5'd0) begin d = 32'h0; b = 1'b0; end
    return {b, d};
  endfunction

  function automatic logic [16:0] exp_par(input logic [2:0] ra);
    logic [15:0] d;
    logic        b;
    d = q_regs[ra];
    b = q_busy[ra];
    if (BYP && p_we && p_waddr == ra) begin
      d = p_wdata;
      b = p_rsv_en && (p_rsv_addr == p_waddr);
    end
    return {b, d};
  endfunction

  logic [32:0] e_a, e_b;
  logic [16:0] f_a, f_b;
  logic [31:0] e_vec;
  logic [7:0]  f_vec;

  // Compare every output of both instances against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      e_a = exp_main(raddr_a);
      e_b = exp_main(raddr_b);
      for (int i = 0; i < 32; i++) e_vec[i] = m_busy[i];
      chk("m_rdata_a", rdata_a, e_a[31:0]);
      chk("m_rbusy_a", rbusy_a, e_a[32]);
      chk("m_rdata_b", rdata_b, e_b[31:0]);
      chk("m_rbusy_b", rbusy_b, e_b[32]);
      chk("m_busy_vec", busy_vec, e_vec);
      f_a = exp_par(p_raddr_a);
      f_b = exp_par(p_raddr_b);
      for (int i = 0; i < 8; i++) f_vec[i] = q_busy[i];
      chk("p_rdata_a", p_rdata_a, f_a[15:0]);
      chk("p_rbusy_a", p_rbusy_a, f_a[16]);
      chk("p_rdata_b", p_rdata_b, f_b[15:0]);
      chk("p_rbusy_b", p_rbusy_b, f_b[16]);
      chk("p_busy_vec", p_busy_vec, f_vec);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; rsv_en = 1'b0;
    p_we = 1'b0; p_rsv_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; rsv_en = 1'b0; waddr = 5'd0; wdata = 32'h0;
    rsv_addr = 5'd0; raddr_a = 5'd0; raddr_b = 5'd0;
    p_we = 1'b0; p_rsv_en = 1'b0; p_waddr = 3'd0; p_wdata = 16'h0;
    p_rsv_addr = 3'd0; p_raddr_a = 3'd0; p_raddr_b = 3'd0;
    tick(); tick();
    idle();
    chk_en = 1'b1;

    // 1. reset clears data and overrides simultaneous write/reserve
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick(); idle(); raddr_a = 5'd5; #1;
    chk("wr_r5", rdata_a, 32'hDEADBEEF);
    rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'h00001234;
    rsv_en = 1'b1; rsv_addr = 5'd6;
    tick(); idle(); #1;
    chk("rst_r5", rdata_a, 32'h0);
    chk("rst_busy_vec", busy_vec, 32'h0);

    // 2. write/read, zero register ignores writes
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
    tick(); idle(); raddr_a = 5'd7; #1;
    chk("rd_r7", rdata_a, 32'h12345678);
    chk("rd_r7_busy", rbusy_a, 1'b0);
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    tick(); idle(); raddr_b = 5'd0; #1;
    chk("rd_r0", rdata_b, 32'h0);
    chk("rd_r0_busy", rbusy_b, 1'b0);

    // 3. scoreboard reserve then release
    rsv_en = 1'b1; rsv_addr = 5'd3;
    tick(); idle(); raddr_a = 5'd3; #1;
    chk("rsv_r3_busy", rbusy_a, 1'b1);
    chk("rsv_r3_vec", busy_vec[3], 1'b1);
    we = 1'b1; waddr = 5'd3; wdata = 32'h000000A5;
    tick(); idle(); #1;
    chk("rel_r3_busy", rbusy_a, 1'b0);
    chk("rel_r3_data", rdata_a, 32'h000000A5);
    rsv_en = 1'b1; rsv_addr = 5'd0;
    tick(); idle(); #1;
    chk("rsv_r0_vec", busy_vec, 32'h0);

    // 4. reserve and write to the same register, re-reserve, then reset
    rsv_en = 1'b1; rsv_addr = 5'd4; we = 1'b1; waddr = 5'd4; wdata = 32'h00000055;
    tick(); idle(); raddr_a = 5'd4; #1;
    chk("col_r4_vec", busy_vec[4], 1'b1);
    chk("col_r4_data", rdata_a, 32'h00000055);
    chk("col_r4_busy", rbusy_a, 1'b1);
    rsv_en = 1'b1; rsv_addr = 5'd4;
    tick(); idle(); #1;
    chk("rersv_r4", busy_vec, 32'h00000010);
    rst = 1'b1;
    tick(); idle(); #1;
    chk("rst_rsv_vec", busy_vec, 32'h0);
    chk("rst_rsv_busy", rbusy_a, 1'b0);

    // 5. write bypass behaviour
    we = 1'b1; waddr = 5'd9; wdata = 32'h00000011;
    tick(); idle();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick(); idle();
    we = 1'b1; waddr = 5'd9; wdata = 32'h00000077; raddr_a = 5'd9; #1;
    chk("byp_r9_data", rdata_a, BYP ? 32'h00000077 : 32'h00000011);
    chk("byp_r9_busy", rbusy_a, BYP ? 1'b0 : 1'b1);
    tick(); idle(); #1;
    chk("post_r9_data", rdata_a, 32'h00000077);
    chk("post_r9_busy", rbusy_a, 1'b0);
    we = 1'b1; waddr = 5'd10; wdata = 32'h00000099; rsv_en = 1'b1; rsv_addr = 5'd10;
    raddr_b = 5'd10; #1;
    chk("byp_rsv_data", rdata_b, BYP ? 32'h00000099 : 32'h0);
    chk("byp_rsv_busy", rbusy_b, BYP ? 1'b1 : 1'b0);
    tick(); idle();
    we = 1'b1; waddr = 5'd0; wdata = 32'h00000123; raddr_a = 5'd0; #1;
    chk("byp_r0_data", rdata_a, 32'h0);
    tick(); idle();

    // 6. parametrised instance: r0 is an ordinary register
    p_we = 1'b1; p_waddr = 3'd0; p_wdata = 16'hBEEF;
    tick(); idle(); p_raddr_a = 3'd0; #1;
    chk("p_r0_data", p_rdata_a, 16'hBEEF);
    p_rsv_en = 1'b1; p_rsv_addr = 3'd0;
    tick(); idle(); #1;
    chk("p_r0_busy", p_busy_vec, 8'h01);

    // Random traffic on both instances, checked by the model every cycle.
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 49) == 0);
      we         = $urandom_range(0, 1);
      waddr      = 5'($urandom_range(0, 31));
      wdata      = $urandom;
      rsv_en     = $urandom_range(0, 1);
      rsv_addr   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr_a    = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr_b    = 5'($urandom_range(0, 31));
      p_we       = $urandom_range(0, 1);
      p_waddr    = 3'($urandom_range(0, 7));
      p_wdata    = 16'($urandom);
      p_rsv_en   = $urandom_range(0, 1);
      p_rsv_addr = ($urandom_range(0, 3) == 0) ? p_waddr : 3'($urandom_range(0, 7));
      p_raddr_a  = ($urandom_range(0, 2) == 0) ? p_waddr : 3'($urandom_range(0, 7));
      p_raddr_b  = 3'($urandom_range(0, 7));
      tick();
    end
    idle();
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised register file for the five-stage pipeline.
- Write port uses a generic one-hot address decoder, the parametrised successor of the fixed 5-to-32 decoder.
- Two combinational read ports.
- Per-register busy scoreboard: the issue stage reserves a destination register, and writeback releases it.
- Sits between the decode stage (reads, reservations) and the writeback stage (writes).

Parameters:
- ADDR_W, 5: register address width; NUM_REGS = 2**ADDR_W.
- DATA_W, 32: register data width.
- ZERO_REG, 1: 1 means register 0 is hardwired to zero and is never busy; 0 means register 0 is an ordinary register.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write enable (writeback).
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- rsv_en  in  1  reserve destination (issue).
- rsv_addr  in  ADDR_W  register to mark busy.
- raddr_a  in  ADDR_W  read address, port A.
- rdata_a  out  DATA_W  read data, port A.
- rbusy_a  out  1  register A has a pending write.
- raddr_b  in  ADDR_W  read address, port B.
- rdata_b  out  DATA_W  read data, port B.
- rbusy_b  out  1  register B has a pending write.
- busy_vec  out  NUM_REGS  full scoreboard, bit i = register i busy.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset: on a rising edge with rst=1, all registers are cleared to 0 and all busy bits to 0. During that cycle rdata_* are combinationally driven from the cleared array, so they read 0 after the edge; rbusy_* and busy_vec are 0. Reset overrides simultaneous we/rsv_en. Reset mid-operation discards all pending reservations.
- Write decode: waddr goes through the one-hot decoder. On an edge with we=1, register[waddr] <= wdata and busy[waddr] <= 0. Write latency is 1 cycle.
- Zero register: with ZERO_REG=1, writes and reservations to address 0 are ignored; reads of address 0 return 0 and busy 0.
- Reserve: on an edge with rsv_en=1, busy[rsv_addr] <= 1.
- Reserve and write to the same address in one cycle: the reservation wins and busy stays 1 (a new producer supersedes the retiring one), while the data write still occurs. Reserve and write to different addresses are independent.
- Reserve of an already-busy register: busy stays 1; no error and no count (single outstanding producer per register).
- Write to a non-busy register is legal; busy stays 0.
- Reads: combinational. rdata_x = register[raddr_x]; rbusy_x = busy[raddr_x], subject to the bypass rules in Optional Feature. Ports A and B may use the same address.
- Width rules: addresses are unsigned, and all NUM_REGS addresses are valid, so there is no out-of-range case. wdata is stored verbatim.
- busy_vec reflects registered busy state only (no bypass).

Optional Feature:
Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: if we=1 and waddr==raddr_x (and not the zero register), rdata_x=wdata in the same cycle. rbusy_x=0 unless rsv_en=1 with rsv_addr==waddr in that same cycle, in which case rbusy_x=1. This gives write-through; writeback and decode may overlap with no stall.
- Undefined: reads return the registered value and registered busy; the pipeline stalls one extra cycle.

Decomposition:
- Shared package `regfile_pkg`: default ADDR_W/DATA_W constants, the NUM_REGS derivation, and typedefs for reg_addr_t and reg_data_t.
- Sub-module `decoder_onehot` (parameter N_IN):
  - output = 1 << in when enable is asserted, else 0.
  - Instantiated twice: once for the write decode and once for the reserve decode.

Test Plan:
1. Reset: rst=1 for 1 edge after writing 0xDEADBEEF to r5 -> rdata_a(r5)=0, busy_vec=0.
2. Write/read: we, r7<=0x12345678; the next cycle raddr_a=7 -> rdata_a=0x12345678, rbusy_a=0. A write of 0xFFFFFFFF to r0 leaves rdata_b(r0)=0.
3. Scoreboard: rsv r3 -> rbusy_a(r3)=1 and busy_vec[3]=1 next cycle; write r3=0xA5 -> busy clears the following cycle and data reads 0xA5.
4. Collision: in the same cycle, rsv r4 and write r4=0x55 -> busy[4]=1 and register=0x55. Then rst mid-reservation -> busy[4]=0.
5. Bypass: with REGFILE_WRITE_BYPASS_EN, we r9=0x77 and raddr_a=9 in the same cycle -> rdata_a=0x77 and rbusy_a=0 combinationally. Without the macro -> old value, and rbusy_a equals the prior busy.
6. Parametrisation: ADDR_W=3, DATA_W=16, ZERO_REG=0 -> r0 is writable; a random write/reserve/read sequence matches the reference model across all 8 registers.
